rf_wb_arbiter: RTL

Write-back arbiter for the register file's single write port. It accepts write requests from two producers: requester 0 is the ALU write-back and requester 1 is the load/memory write-back. Each requester is buffered in its own 2-deep FIFO, and the FIFO heads are granted round-robin to a registered write stage that drives `we`/`rd`/`indata` of the register file. It also publishes a pending-write mask so decode can stall on registers with writes still in flight.

---
 rtl/rf_wb_if.sv | 34 +++
 rtl/rf_wb_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/rf_wb_if.sv
// Bundle between the write-back producers, the arbiter and the register file write port.
// The slave modport is the arbiter's view; the master modport is the producer/register-file side.
interface rf_wb_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          req0_valid;
  logic [AW-1:0] req0_rd;
  logic [DW-1:0] req0_data;
  logic          req0_ready;
  logic          req1_valid;
  logic [AW-1:0] req1_rd;
  logic [DW-1:0] req1_data;
  logic          req1_ready;
  logic          rf_we;
  logic [AW-1:0] rf_rd;
  logic [DW-1:0] rf_wdata;
  logic [31:0]   pend_mask;
  logic          idle;

  modport master (
    output req0_valid, req0_rd, req0_data,
    output req1_valid, req1_rd, req1_data,
    input  req0_ready, req1_ready,
    input  rf_we, rf_rd, rf_wdata, pend_mask, idle
  );

  modport slave (
    input  req0_valid, req0_rd, req0_data,
    input  req1_valid, req1_rd, req1_data,
    output req0_ready, req1_ready,
    output rf_we, rf_rd, rf_wdata, pend_mask, idle
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Two-requester write-back arbiter: 2-deep FIFO per requester, round-robin grant into a registered
// write stage, plus a pending-write mask. Define RF_WB_FIXED_PRIO_EN for strict requester-0 priority.
module rf_wb_arbiter #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input logic   clk,
  input logic   rst,
  rf_wb_if.slave bus
);

  logic [AW-1:0] q_rd_r   [2][2];
  logic [DW-1:0] q_data_r [2][2];
  logic [1:0]    cnt_r    [2];
  logic          rptr_r   [2];
  logic          wptr_r   [2];

  logic          rf_we_r;
  logic [AW-1:0] rf_rd_r;
  logic [DW-1:0] rf_wdata_r;
`ifndef RF_WB_FIXED_PRIO_EN
  logic          last_grant_r;
`endif

  logic [1:0]    req_valid_s;
  logic [AW-1:0] req_rd_s   [2];
  logic [DW-1:0] req_data_s [2];
  logic [1:0]    ready_s;
  logic [1:0]    nonempty_s;
  logic [1:0]    push_s;
  logic [1:0]    pop_s;
  logic          gnt_valid_s;
  logic          gnt_sel_s;
  logic [AW-1:0] head_rd_s;
  logic [DW-1:0] head_data_s;
  logic [31:0]   pend_s;

  // Requester-side status; ready depends on the count only, so a same-cycle pop never raises it
  always_comb begin
    req_valid_s   = {bus.req1_valid, bus.req0_valid};
    req_rd_s[0]   = bus.req0_rd;
    req_rd_s[1]   = bus.req1_rd;
    req_data_s[0] = bus.req0_data;
    req_data_s[1] = bus.req1_data;
    for (int n = 0; n < 2; n++) begin
      ready_s[n]    = (cnt_r[n] != 2'd2);
      nonempty_s[n] = (cnt_r[n] != 2'd0);
      push_s[n]     = req_valid_s[n] & ready_s[n];
    end
  end

  // Grant selection and head read-out
  always_comb begin
    gnt_valid_s = |nonempty_s;
`ifdef RF_WB_FIXED_PRIO_EN
    gnt_sel_s = ~nonempty_s[0];
`else
    if (&nonempty_s) begin
      gnt_sel_s = ~last_grant_r;
    end else begin
      gnt_sel_s = ~nonempty_s[0];
    end
`endif
    pop_s = 2'b00;
    if (gnt_valid_s) begin
      pop_s[gnt_sel_s] = 1'b1;
    end else begin
      pop_s = 2'b00;
    end
    head_rd_s   = q_rd_r[gnt_sel_s][rptr_r[gnt_sel_s]];
    head_data_s = q_data_r[gnt_sel_s][rptr_r[gnt_sel_s]];
  end

  // Per-requester FIFO storage, pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < 2; n++) begin
        cnt_r[n]  <= 2'd0;
        rptr_r[n] <= 1'b0;
        wptr_r[n] <= 1'b0;
        for (int s = 0; s < 2; s++) begin
          q_rd_r[n][s]   <= {AW{1'b0}};
          q_data_r[n][s] <= {DW{1'b0}};
        end
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (push_s[n]) begin
          q_rd_r[n][wptr_r[n]]   <= req_rd_s[n];
          q_data_r[n][wptr_r[n]] <= req_data_s[n];
          wptr_r[n]              <= ~wptr_r[n];
        end
        if (pop_s[n]) begin
          rptr_r[n] <= ~rptr_r[n];
        end
        case ({push_s[n], pop_s[n]})
          2'b10:   cnt_r[n] <= cnt_r[n] + 2'd1;
          2'b01:   cnt_r[n] <= cnt_r[n] - 2'd1;
          default: cnt_r[n] <= cnt_r[n];
        endcase
      end
    end
  end

  // Write stage; x0 entries are consumed but never enable the write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_r    <= 1'b0;
      rf_rd_r    <= {AW{1'b0}};
      rf_wdata_r <= {DW{1'b0}};
    end else if (gnt_valid_s) begin
      rf_we_r    <= (head_rd_s != {AW{1'b0}});
      rf_rd_r    <= head_rd_s;
      rf_wdata_r <= head_data_s;
    end else begin
      rf_we_r    <= 1'b0;
    end
  end

`ifndef RF_WB_FIXED_PRIO_EN
  // Round-robin history, reset to 1 so requester 0 wins the first contention
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_r <= 1'b1;
    end else if (gnt_valid_s) begin
      last_grant_r <= gnt_sel_s;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end
`endif

  // Pending-write mask over every live FIFO slot plus an active write stage
  always_comb begin
    pend_s = 32'd0;
    for (int n = 0; n < 2; n++) begin
      for (int s = 0; s < 2; s++) begin
        if ((cnt_r[n] == 2'd2) || ((cnt_r[n] == 2'd1) && (s == int'(rptr_r[n])))) begin
          pend_s[q_rd_r[n][s]] = 1'b1;
        end else begin
          pend_s = pend_s;
        end
      end
    end
    if (rf_we_r) begin
      pend_s[rf_rd_r] = 1'b1;
    end else begin
      pend_s = pend_s;
    end
    pend_s[0] = 1'b0;
  end

  assign bus.req0_ready = ready_s[0];
  assign bus.req1_ready = ready_s[1];
  assign bus.rf_we      = rf_we_r;
  assign bus.rf_rd      = rf_rd_r;
  assign bus.rf_wdata   = rf_wdata_r;
  assign bus.pend_mask  = pend_s;
  assign bus.idle       = ~nonempty_s[0] & ~nonempty_s[1] & ~rf_we_r;

endmodule
